// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   arb_state_t  - arbiter FSM states
//   mem_req_t    - latched access {we, addr, wdata}
//   mem_rsp_t    - registered response {rdata, err}
//   addr_legal() - in-range and word-aligned test
package dmem_arb_pkg;

    localparam int ARB_ADDR_W        = 32;
    localparam int ARB_DATA_W        = 32;
    localparam int DEFAULT_MEM_BYTES = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] rdata;
        logic                  err;
    } mem_rsp_t;

    // An access is legal only if it falls inside the decoded window
    // and is word aligned.
    function automatic logic addr_legal(input logic [ARB_ADDR_W-1:0] addr,
                                        input int unsigned           mem_bytes);
        return (addr < ARB_ADDR_W'(mem_bytes)) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (one instance per port).
// Latency: gnt one cycle after req is sampled, rvalid one cycle after gnt.
// Backpressure: req/we/addr/wdata held stable until gnt; no response stall.
//
// Signals: req, we, addr, wdata (requester -> arbiter);
//          gnt, rvalid, rdata, err (arbiter -> requester).
// Modports: master = requester, slave = arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: returns the port that should win this cycle.
// Latency: purely combinational.
// Backpressure: none; caller decides when a pick is consumed.
//
// Ports: req[1:0] requests, last = port granted most recently,
//        win = winning port id (don't-care when req == 0).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);
    // Contention goes to the port not served last; otherwise the lone
    // requester wins (req[1] alone -> 1, req[0] alone -> 0).
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between port 0 (LSU) and port 1 (DMA/debug).
// Latency: req sampled at t -> gnt at t+1 -> rvalid at t+2; one access per 2 cycles.
// Backpressure: losing/unsampled requests wait (req held); responses cannot stall.
//
// Ports: clk, rst_n (async active-low); m0/m1 requester buses (slave modport);
//        mem_addr/mem_wdata/mem_we to memory, mem_rdata combinational read back.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
// wins contention, no round-robin pointer); default is round robin.
// The struct fields are sized by the package constants; ADDR_W/DATA_W must match.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    mem_req_t   lat_q;
    mem_req_t   sel_req;
    mem_rsp_t   rsp_q;
    logic       win_q;       // port id of the access in flight
    logic       arb_win;     // port id chosen this cycle
    logic       take;        // a request is latched this cycle
    logic       in_access;
    logic       in_resp;
    logic       legal;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks; port 1 only when port 0 is quiet.
    assign arb_win = ~m0.req;
`else
    logic [1:0] req_vec;
    logic       last_q;      // port served most recently

    assign req_vec = {m1.req, m0.req};

    rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (last_q),
        .win  (arb_win)
    );

    // Reset to "port 1 served last" so the first contention goes to port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= arb_win;
        end
    end
`endif

    assign sel_req = arb_win ? '{we: m1.we, addr: m1.addr, wdata: m1.wdata}
                             : '{we: m0.we, addr: m0.addr, wdata: m0.wdata};

    assign legal = addr_legal(lat_q.addr, MEM_BYTES);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        in_access = 1'b0;
        in_resp   = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                // RESP also arbitrates so a new access can start back to back.
                in_resp = (state_q == RESP);
                if (m0.req || m1.req) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                in_access = 1'b1;
                state_d   = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access latch and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
            win_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            if (take) begin
                lat_q <= sel_req;
                win_q <= arb_win;
            end
            if (in_access) begin
                // Writes and rejected accesses report zero data.
                rsp_q.rdata <= (lat_q.we || !legal) ? '0 : mem_rdata;
                rsp_q.err   <= ~legal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory side: the latch holds its value outside ACCESS, so the
    // address stays at the last access; the write strobe is pure decode
    // of state so an asynchronous reset kills it immediately.
    // ------------------------------------------------------------------
    assign mem_addr  = lat_q.addr;
    assign mem_wdata = lat_q.wdata;
    assign mem_we    = in_access & lat_q.we & legal;

    // ------------------------------------------------------------------
    // Requester side: data/err are forced to zero outside the strobe.
    // ------------------------------------------------------------------
    assign m0.gnt    = in_access & ~win_q;
    assign m1.gnt    = in_access &  win_q;
    assign m0.rvalid = in_resp   & ~win_q;
    assign m1.rvalid = in_resp   &  win_q;
    assign m0.rdata  = m0.rvalid ? rsp_q.rdata : '0;
    assign m1.rdata  = m1.rvalid ? rsp_q.rdata : '0;
    assign m0.err    = m0.rvalid & rsp_q.err;
    assign m1.err    = m1.rvalid & rsp_q.err;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Arbitrates, latches one access, drives the memory's address/write-data/write-enable, and returns a registered, one-cycle response with an error flag.
- Sits between the requesters and the data memory. The memory has a combinational read, a synchronous word write, and word index addr>>2.

Parameters:
- MEM_BYTES, 4096, decoded memory size in bytes; addresses >= MEM_BYTES are out of range.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word access only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 request; held until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  one-cycle grant; request consumed.
- m0_rvalid  out  1  one-cycle response strobe (reads and writes).
- m0_rdata  out  DATA_W  read data; 0 on write or error.
- m0_err  out  1  valid with m0_rvalid: out-of-range or misaligned.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_we  out  1  memory write enable (MemRW).
- mem_rdata  in  DATA_W  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all gnt/rvalid/err = 0; rdata = 0; mem_addr = 0; mem_wdata = 0; mem_we = 0; round-robin pointer favours port 0.
- Arbitration is evaluated in IDLE and RESP.
  - If any req is high: pick a winner; latch winner id, we, addr, wdata; go to ACCESS.
  - Otherwise: RESP goes to IDLE, and IDLE stays in IDLE.
- Round robin: both requesting, the port not served last wins; one requesting, that port wins. Pointer updates only on grant.
- ACCESS, one cycle:
  - Assert the winner's gnt.
  - Drive mem_addr/mem_wdata from the latched values.
  - mem_we = latched we AND legal.
  - Capture mem_rdata, or 0 for a write or an illegal access, into the response register.
  - Next state: RESP.
- Legality:
  - Illegal if addr >= MEM_BYTES or addr[1:0] != 0.
  - An illegal access never asserts mem_we.
  - An illegal access returns err = 1 and rdata = 0.
- RESP: assert the winner's rvalid, with rdata/err, for exactly one cycle. Arbitration runs in the same cycle.
- Latency and throughput:
  - Request high in an arbitrating cycle t.
  - gnt at t+1.
  - rvalid at t+2.
  - Sustained throughput: one access every 2 cycles.
- Outside ACCESS: mem_we = 0 and mem_addr holds its last value.
- Request rules:
  - The requester must hold req/we/addr/wdata stable until gnt.
  - Inputs after latching are ignored.
  - A req that drops before it is sampled is simply not served.
- Simultaneous events:
  - A requester may raise a new req in the same cycle its rvalid is high; that req is arbitrated that cycle.
  - The loser of arbitration keeps waiting and wins next time under round robin.
- Reset asserted mid-ACCESS: the write is aborted (mem_we drops asynchronously), no response is issued, and the block returns to reset values.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both request; the round-robin pointer is not implemented. Port 1 can starve under continuous port 0 traffic; this is accepted.
- Undefined: round-robin arbitration as specified above.

Decomposition:
- Package dmem_arb_pkg holds:
  - Enum arb_state_t {IDLE, ACCESS, RESP}.
  - Localparam default MEM_BYTES = 4096.
  - Struct mem_req_t {we, addr, wdata}.
  - Struct mem_rsp_t {rdata, err}.
- Sub-module rr_arb2: 2-input round-robin picker taking req[1:0] and a last-grant bit, returning the winner. It is bypassed when DMEM_ARB_FIXED_PRIO_EN is defined.

Test Plan:
- Port 0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 → write: gnt at t+1, mem_we for one cycle, rvalid at t+2 with err = 0. Read: rdata = 0xDEADBEEF, err = 0.
- Both ports read continuously (m0 addr 0x0, m1 addr 0x4) → grants alternate 0,1,0,1. Without DMEM_ARB_FIXED_PRIO_EN, each port gets one rvalid per 4 cycles. With it, only port 0 is served.
- Port 1 writes to addr 0x1000 (=4096) and to addr 0x6 → each gives rvalid with err = 1 and rdata = 0. mem_we is never asserted, and a read of 0x1000&0xFFC is unchanged.
- Port 0 issues a write; rst_n is pulsed low during ACCESS → mem_we falls immediately, no rvalid follows, all outputs are 0, and the next request behaves as after reset.
- Port 1 req for one cycle while port 0 holds the grant, then drops → port 1 gets no gnt/rvalid and the memory is unaffected.
- Port 0 raises a new request in its rvalid cycle → gnt on the next cycle, i.e. back-to-back 2-cycle spacing.
